// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary converter family.
// Holds the converter FSM states and the digit-range helpers.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Smallest binary width that holds every N-digit decimal value.
  function automatic int bcd_bin_width(input int n);
    return $clog2(10 ** n);
  endfunction

  function automatic logic isBcdDigit(input logic [3:0] d);
    return d <= BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_bin.sv
// Sequential BCD-to-binary converter: one digit per cycle, MSD first,
// acc = acc*10 + digit, with valid/ready on both sides and a non-BCD flag.
module bcd_bin
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = bcd_bin_width(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] bcd_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [BIN_W-1:0]      bin_o,
  output logic                  err_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  localparam int CNT_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int WORD_W = 4 * N_DIGITS;

  state_e              state_q, state_d;
  logic [BIN_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                err_q, err_d;
  logic [3:0]          digit;

  // The captured word shifts left each CONV cycle, so the next digit is always on top.
  assign digit = word_q[WORD_W-1 -: 4];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          word_d  = bcd_i;
          acc_d   = '0;
          cnt_d   = CNT_W'(N_DIGITS - 1);
          err_d   = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        // x*10 as (x<<3)+(x<<1), widened so the intermediate never wraps.
        acc_d  = BIN_W'(({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1)
                        + (BIN_W + 4)'(digit));
        err_d  = err_q | ~isBcdDigit(digit);
        word_d = word_q << 4;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign bin_o       = (out_valid_o && !err_q) ? acc_q : '0;
  assign err_o       = out_valid_o & err_q;

endmodule

// File: tb/tb_bcd_bin.sv
// Self-checking bench for bcd_bin: directed cases, exhaustive 0000-9999 sweep
// and random words, all scored against a decimal-arithmetic reference model.
module tb_bcd_bin;

  localparam int N     = 4;
  localparam int W     = 4 * N;
  localparam int BIN_W = 14;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [W-1:0]     bcd_i = '0;
  logic             in_valid_i = 1'b0;
  logic             out_ready_i = 1'b0;
  logic             in_ready_o;
  logic             out_valid_o;
  logic             err_o;
  logic [BIN_W-1:0] bin_o;

  int nVec  = 0;
  int nFail = 0;
  int cycle = 0;
  int lastAccept = 0;
  bit haveLast = 1'b0;
  bit seenValid = 1'b0;

  typedef struct {
    int val;
    bit err;
    int acceptCycle;
  } exp_t;
  exp_t expQ[$];

  always #5 clk = ~clk;

  bcd_bin #(.N_DIGITS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_i      (bcd_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .bin_o      (bin_o),
    .err_o      (err_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  // Reference: read each nibble as a decimal digit and weight it by its power of ten.
  function automatic void refModel(input logic [W-1:0] w, output int val, output bit err);
    int scale = 1;
    val = 0;
    err = 1'b0;
    for (int k = 0; k < N; k++) begin
      int d = int'((w >> (4 * k)) & 16'hF);
      if (d > 9) err = 1'b1;
      val += d * scale;
      scale *= 10;
    end
    if (err) val = 0;
  endfunction

  function automatic logic [W-1:0] toBcd(input int v);
    logic [W-1:0] w = '0;
    int r = v;
    for (int k = 0; k < N; k++) begin
      w[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVec++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Acceptance and retirement are observed at the active edge, before the DUT updates.
  initial begin
    forever begin
      @(posedge clk);
      cycle++;
      if (!rst) begin
        if (in_valid_i && in_ready_o) begin
          exp_t e;
          refModel(bcd_i, e.val, e.err);
          e.acceptCycle = cycle;
          expQ.push_back(e);
          if (haveLast)
            checkOutput("accept spacing >= N+2", (cycle - lastAccept >= N + 2) ? 1 : 0, 1);
          lastAccept = cycle;
          haveLast = 1'b1;
        end
        if (out_valid_o && out_ready_i && expQ.size() > 0) begin
          void'(expQ.pop_front());
          seenValid = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge rst);
      expQ.delete();
      seenValid = 1'b0;
      haveLast = 1'b0;
    end
  end

  // Compare process: outputs are sampled mid-cycle against the model queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("reset in_ready_o", in_ready_o, 1);
        checkOutput("reset out_valid_o", out_valid_o, 0);
        checkOutput("reset bin_o", bin_o, 0);
        checkOutput("reset err_o", err_o, 0);
      end else begin
        checkOutput("in_ready/out_valid overlap", in_ready_o & out_valid_o, 0);
        if (out_valid_o) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected out_valid_o", 1, 0);
          end else begin
            checkOutput("model bin_o", bin_o, expQ[0].val);
            checkOutput("model err_o", err_o, expQ[0].err);
            if (!seenValid) begin
              checkOutput("latency", cycle - expQ[0].acceptCycle, N);
              seenValid = 1'b1;
            end
          end
        end else if (expQ.size() > 0 && !seenValid && cycle - expQ[0].acceptCycle == N) begin
          checkOutput("out_valid_o rise", 0, 1);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] word, input int stall,
                               input int expBin, input bit expErr, input string name);
    int guard = 0;
    bcd_i = word;
    in_valid_i = 1'b1;
    while (!in_ready_o && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready_o) checkOutput({name, " accept timeout"}, 0, 1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    bcd_i = W'($urandom);
    checkOutput({name, " in_ready drop"}, in_ready_o, 0);
    guard = 0;
    while (!out_valid_o && guard < 50) begin
      out_ready_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      guard++;
    end
    out_ready_i = 1'b0;
    if (!out_valid_o) begin
      checkOutput({name, " result timeout"}, 0, 1);
    end else begin
      checkOutput({name, " bin_o"}, bin_o, expBin);
      checkOutput({name, " err_o"}, err_o, expErr);
    end
    repeat (stall) begin
      @(posedge clk); #1;
      checkOutput({name, " held valid"}, out_valid_o, 1);
      checkOutput({name, " held bin_o"}, bin_o, expBin);
      checkOutput({name, " in_ready low"}, in_ready_o, 0);
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    checkOutput({name, " back to idle"}, in_ready_o, 1);
  endtask

  initial begin
    int mv;
    bit me;

    refModel(16'h1234, mv, me);
    checkOutput("model pin 1234", mv, 1234);
    refModel(16'h12A4, mv, me);
    checkOutput("model pin 12A4 err", me, 1);
    refModel(16'h9999, mv, me);
    checkOutput("model pin 9999", mv, 9999);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("post-reset in_ready_o", in_ready_o, 1);
    checkOutput("post-reset out_valid_o", out_valid_o, 0);

    applyStimulus(16'h1234, 0, 1234, 1'b0, "1234");
    applyStimulus(16'h9999, 0, 9999, 1'b0, "9999");
    applyStimulus(16'h0000, 0, 0, 1'b0, "0000");
    applyStimulus(16'h12A4, 0, 0, 1'b1, "12A4");
    applyStimulus(16'hF000, 0, 0, 1'b1, "F000 msd");
    applyStimulus(16'h000B, 0, 0, 1'b1, "000B lsd");
    applyStimulus(16'h0507, 5, 507, 1'b0, "0507 stall");

    // Abort mid-conversion: two digits in, the result must never appear.
    bcd_i = 16'h4321;
    in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("async rst in_ready_o", in_ready_o, 1);
    checkOutput("async rst out_valid_o", out_valid_o, 0);
    checkOutput("async rst bin_o", bin_o, 0);
    checkOutput("async rst err_o", err_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (N + 2) begin
      @(posedge clk); #1;
      checkOutput("no pulse after abort", out_valid_o, 0);
    end
    applyStimulus(16'h0042, 0, 42, 1'b0, "0042");

    for (int v = 0; v < 10000; v++) begin
      applyStimulus(toBcd(v), 0, v, 1'b0, "sweep");
    end

    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] w = W'($urandom);
      refModel(w, mv, me);
      applyStimulus(w, $urandom_range(0, 3), mv, me, "random");
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule

// File: doc/bcd_bin.md
Name: bcd_bin

Overview:
- Sequential BCD-to-binary converter; the reverse direction of the existing bin_bcd block.
- Takes a packed N-digit BCD word and produces the equivalent unsigned binary value.
- Method: multiply-accumulate, one digit per cycle, MSD first (acc = acc*10 + digit).
- Sits between display/keypad-style BCD sources and binary datapaths.
- Uses a valid/ready handshake on both input and output, and flags non-BCD digits.

Parameters:
- N_DIGITS, 4, number of BCD digits in the input word (≥1).
- BIN_W, $clog2(10**N_DIGITS), binary output width; derived, do not override (14 for the default).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- bcd_i  in  4*N_DIGITS  packed BCD input; digit k at bits [4k+3:4k]; digit N_DIGITS-1 is the MSD.
- in_valid_i  in  1  bcd_i is valid.
- in_ready_o  out  1  block can accept a word (high only in IDLE).
- bin_o  out  BIN_W  converted binary value.
- err_o  out  1  at least one input digit was >9; qualified by out_valid_o.
- out_valid_o  out  1  bin_o/err_o valid.
- out_ready_i  in  1  consumer accepts the result.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; in_ready_o=1; out_valid_o=0; bin_o=0; err_o=0.
  - Internal acc, digit counter and captured word are all cleared.
- FSM states are IDLE, CONV and DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i=1 at a rising edge: capture bcd_i into an internal shift register, acc=0, cnt=N_DIGITS-1, err=0, go to CONV.
- CONV (in_ready_o=0, out_valid_o=0), each cycle:
  - d = captured digit[cnt].
  - acc <= (acc<<3) + (acc<<1) + d, computed at BIN_W+4 bits internally and truncated to BIN_W.
  - err <= err | (d>9).
  - If cnt==0, go to DONE; else cnt <= cnt-1.
  - Exactly N_DIGITS cycles are spent in CONV.
- DONE:
  - out_valid_o=1.
  - bin_o = err ? 0 : acc. An invalid word always reports bin_o=0 with err_o=1.
  - bin_o and err_o are held stable while out_ready_i=0 (arbitrary backpressure).
  - On out_ready_i=1 at an edge, go to IDLE.
- Latency: input accepted at edge T; out_valid_o rises after edge T+N_DIGITS.
- Throughput: min N_DIGITS+2 cycles per word. The IDLE turnaround cycle is mandatory; in_ready_o never overlaps out_valid_o.
- Boundaries:
  - All-zero input gives bin_o=0, err_o=0.
  - Max valid input (all 9s) gives 10**N_DIGITS-1, which fits BIN_W with no overflow.
  - Digits 0xA–0xF anywhere, including MSD only or LSD only, set err_o.
  - bcd_i changes after capture have no effect on the conversion in progress.
  - in_valid_i outside IDLE is ignored; the source must hold it until in_ready_o.
  - out_ready_i outside DONE is ignored.
  - rst asserted mid-CONV or in DONE aborts immediately; the pending result is lost and no out_valid_o pulse is produced.
  - N_DIGITS=1: a single CONV cycle; BIN_W=4.

Decomposition:
- Shared package bcd_pkg holds:
  - the state enum (IDLE, CONV, DONE), shared with bin_bcd if it is refactored;
  - localparam BCD_MAX_DIGIT=4'd9;
  - function bcd_bin_width(n) returning $clog2(10**n).
- No sub-module needed. The ×10 add is a single expression inside the FSM module.
- Keep the digit-valid check as a package function so bin_bcd benches can reuse it.

Test Plan:
- Reset, then bcd_i=16'h1234 with valid for 1 cycle → in_ready_o drops next cycle; out_valid_o high 4 cycles after acceptance; bin_o=14'd1234 (0x4D2), err_o=0.
- bcd_i=16'h9999, then 16'h0000, back-to-back with out_ready_i=1 → bin_o=9999 (0x270F), then 0. Second accept must occur no earlier than 6 cycles after the first.
- bcd_i=16'h12A4 → err_o=1, bin_o=0. Repeat with 16'hF000 → err_o=1.
- bcd_i=16'h0507 with out_ready_i=0 for 5 cycles after out_valid_o → bin_o=507 and out_valid_o held stable; in_ready_o=0 throughout; IDLE is entered the edge after out_ready_i=1.
- Accept 16'h4321, assert rst for 1 cycle mid-CONV (cnt=2) → all outputs at reset values asynchronously; no out_valid_o pulse. A new 16'h0042 then converts to 42.
- Exhaustive sweep 0000–9999, compared against a reference model → 0 errors reported by checkErrors.
